// File: rtl/bnn_fc_engine_if.sv
// Stream bundle for the binary FC engine: weight/activation sinks, result source, frame control.
// The engine attaches through the slave modport; the frame driver uses master.
interface bnn_fc_engine_if #(
  parameter int PAR   = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 4
);
  logic             start;
  logic             reuse_w;
  logic             weight_tvalid;
  logic [PAR-1:0]   weight_tdata;
  logic             weight_tready;
  logic             act_tvalid;
  logic [PAR-1:0]   act_tdata;
  logic             act_tready;
  logic             result_tvalid;
  logic [ACC_W-1:0] result_tdata;
  logic             result_tready;
  logic             result_tlast;
  logic             done;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output start, reuse_w, weight_tvalid, weight_tdata, act_tvalid, act_tdata, result_tready,
    input  weight_tready, act_tready, result_tvalid, result_tdata, result_tlast, done, out_cnt
  );

  modport slave (
    input  start, reuse_w, weight_tvalid, weight_tdata, act_tvalid, act_tdata, result_tready,
    output weight_tready, act_tready, result_tvalid, result_tdata, result_tlast, done, out_cnt
  );
endinterface

// File: rtl/bnn_fc_engine.sv
// Binary fully-connected layer: loads 1-bit weights and one activation vector in PAR-bit beats,
// then streams one signed XNOR-popcount dot product (or its sign) per output channel.
module bnn_fc_engine #(
  parameter int IN_LEN  = 64,
  parameter int OUT_CH  = 10,
  parameter int PAR     = 8,
  parameter int ACC_W   = 32,
  parameter int BIN_OUT = 0
) (
  input  logic             clk,
  input  logic             rstn,
  bnn_fc_engine_if.slave   bus
);
  localparam int BPC   = IN_LEN / PAR;
  localparam int BEAT_W = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int CNT_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int POP_W = $clog2(IN_LEN + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_LOAD_A = 3'd2;
  localparam logic [2:0] S_CALC   = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        r_state;
  logic              r_w_valid;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0]  r_wch;
  logic [CNT_W-1:0]  r_ch;
  logic [ACC_W-1:0]  r_result;
  logic [IN_LEN-1:0] r_wmem [OUT_CH];
  logic [IN_LEN-1:0] r_act;

  logic              w_w_hs;
  logic              w_a_hs;
  logic              w_beat_last;
  logic              w_wch_last;
  logic              w_ch_last;
  logic [IN_LEN-1:0] w_mis;
  logic [POP_W-1:0]  w_pop;
  logic signed [ACC_W-1:0] w_dot;
  logic [ACC_W-1:0]  w_res;

  assign w_w_hs      = (r_state == S_LOAD_W) && bus.weight_tvalid;
  assign w_a_hs      = (r_state == S_LOAD_A) && bus.act_tvalid;
  assign w_beat_last = (r_beat == BEAT_W'(BPC - 1));
  assign w_wch_last  = (r_wch == CNT_W'(OUT_CH - 1));
  assign w_ch_last   = (r_ch == CNT_W'(OUT_CH - 1));

  // A mismatching bit contributes -1, a matching bit +1: dot = IN_LEN - 2*mismatches.
  assign w_mis = r_act ^ r_wmem[r_ch];

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < IN_LEN; i++) begin
      w_pop = w_pop + POP_W'(w_mis[i]);
    end
  end

  assign w_dot = ACC_W'(IN_LEN) - (ACC_W'(w_pop) << 1);

  generate
    if (BIN_OUT != 0) begin : g_bin
      assign w_res = w_dot[ACC_W-1] ? {ACC_W{1'b1}} : ACC_W'(1);
    end else begin : g_raw
      assign w_res = w_dot;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_w_valid <= 1'b0;
      r_beat    <= '0;
      r_wch     <= '0;
      r_ch      <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ch <= '0;
          if (bus.start) begin
            r_beat <= '0;
            r_wch  <= '0;
            if (bus.reuse_w && r_w_valid) begin
              r_state <= S_LOAD_A;
            end else begin
              // Invalidate first so an interrupted load can never be reused.
              r_w_valid <= 1'b0;
              r_state   <= S_LOAD_W;
            end
          end
        end
        S_LOAD_W: begin
          if (bus.weight_tvalid) begin
            if (w_beat_last) begin
              r_beat <= '0;
              if (w_wch_last) begin
                r_w_valid <= 1'b1;
                r_state   <= S_LOAD_A;
              end else begin
                r_wch <= r_wch + 1'b1;
              end
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_LOAD_A: begin
          if (bus.act_tvalid) begin
            if (w_beat_last) begin
              r_beat  <= '0;
              r_ch    <= '0;
              r_state <= S_CALC;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_CALC: begin
          r_result <= w_res;
          r_state  <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.result_tready) begin
            if (w_ch_last) begin
              r_state <= S_DONE;
            end else begin
              r_ch    <= r_ch + 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_DONE: begin
          r_ch    <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data stores carry no reset; they are only read after a completed load.
  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      r_wmem[r_wch][32'(r_beat) * PAR +: PAR] <= bus.weight_tdata;
    end
    if (w_a_hs) begin
      r_act[32'(r_beat) * PAR +: PAR] <= bus.act_tdata;
    end
  end

  assign bus.weight_tready = (r_state == S_LOAD_W);
  assign bus.act_tready    = (r_state == S_LOAD_A);
  assign bus.result_tvalid = (r_state == S_EMIT);
  assign bus.result_tdata  = r_result;
  assign bus.result_tlast  = (r_state == S_EMIT) && w_ch_last;
  assign bus.done          = (r_state == S_DONE);
  assign bus.out_cnt       = r_ch;
endmodule
